// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM states and the oversampling constants
// that fix the divisor arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_START = 3'd2,
    MEASURE    = 3'd3,
    CALC       = 3'd4
  } autobaud_state_t;

  localparam int OVS_LOG2       = 4;
  localparam int SYNC_BITS_LOG2 = 3;
  localparam logic [7:0] SYNC_CHAR = 8'h55;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the raw rx pin plus a one-flop edge detector.
// Flops reset to the idle (high) line level so no edge is reported out of reset.
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // synchronizer chain and previous-sample register
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= rx;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rx_s = sync_r;
  assign fall = prev_r & ~sync_r;
  assign rise = ~prev_r & sync_r;

endmodule

// File: rtl/uart_autobaud.sv
// Measures the eight bit times of a received 0x55 sync character and derives the
// 16x-oversampling divisor for the baud generator.
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int DVSR_W   = 11,
  parameter int CNT_W    = DVSR_W + 7,
  parameter int IDLE_CYC = 16,
  parameter int DVSR_RST = 650
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic [DVSR_W-1:0] dvsr,
  output logic              busy,
  output logic              done_tick,
  output logic              err_tick
);

  localparam int SHIFT  = OVS_LOG2 + SYNC_BITS_LOG2;
  localparam int ROUND  = 1 << (SHIFT - 1);
  localparam int IDLE_W = $clog2(IDLE_CYC + 1);
  localparam logic [DVSR_W-1:0] DVSR_INIT = DVSR_W'(DVSR_RST);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  autobaud_state_t    state_r, state_s;
  logic [IDLE_W-1:0]  idle_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [3:0]         edges_r;
  logic [CNT_W:0]     q_s;
  logic               q_ok_s;
  logic [DVSR_W-1:0]  dvsr_r;
  logic               busy_r, done_r, err_r;
  logic               done_s, err_s;
  logic               rx_s, fall, rise, edge_s, eighth_s, ovf_s;

  rx_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall),
    .rise  (rise)
  );

  // cnt_inc_s is the count including the current cycle, so at the 8th edge it
  // equals exactly eight bit periods; the divisor is evaluated from it directly
  // so the result and its tick are registered on entry to CALC.
  assign edge_s    = fall | rise;
  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign eighth_s  = (state_r == MEASURE) && edge_s && (edges_r == 4'd7);
  assign ovf_s     = (state_r == MEASURE) && !eighth_s && (cnt_inc_s == CNT_MAX);
  assign q_s       = ({1'b0, cnt_inc_s} + (CNT_W+1)'(ROUND)) >> SHIFT;
  assign q_ok_s    = (q_s >= (CNT_W+1)'(2)) && (q_s <= (CNT_W+1)'(2**DVSR_W));

  // next-state and tick decode
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_s = ARM;
        else       state_s = IDLE;
      end
      ARM: begin
        if (rx_s && (idle_r == IDLE_W'(IDLE_CYC - 1))) state_s = WAIT_START;
        else                                           state_s = ARM;
      end
      WAIT_START: begin
        if (fall) state_s = MEASURE;
        else      state_s = WAIT_START;
      end
      MEASURE: begin
        if (eighth_s) begin
          state_s = CALC;
          done_s  = q_ok_s;
          err_s   = !q_ok_s;
        end else if (ovf_s) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          state_s = MEASURE;
        end
      end
      CALC:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idle_r  <= '0;
      cnt_r   <= '0;
      edges_r <= 4'd0;
      dvsr_r  <= DVSR_INIT;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
      if (done_s) dvsr_r <= DVSR_W'(q_s - (CNT_W+1)'(1));
      if (state_r == ARM && rx_s) idle_r <= idle_r + IDLE_W'(1);
      else                        idle_r <= '0;
      if (state_r == WAIT_START) begin
        cnt_r   <= '0;
        edges_r <= 4'd0;
      end else if (state_r == MEASURE) begin
        cnt_r   <= cnt_inc_s;
        edges_r <= edges_r + {3'b000, edge_s};
      end
    end
  end

  assign dvsr      = dvsr_r;
  assign busy      = busy_r;
  assign done_tick = done_r;
  assign err_tick  = err_r;

endmodule
